// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp encoding and issue skid-buffer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_CMP   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_ARITH  = 2'b10,
        ALUOP_PASSB  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } issue_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> ALUControl decode.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       ALUSrc,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_PASSB;
        case (alu_op_t'(ALUOp))
            ALUOP_MEM:    ALUControl = ALU_ADD;
            ALUOP_BRANCH: ALUControl = ALU_SUB;
            ALUOP_PASSB:  ALUControl = ALU_PASSB;
            ALUOP_ARITH: begin
                case (funct3)
                    // Immediate forms have bit 30 as part of the immediate, so only R-type subtracts.
                    3'b000:  ALUControl = (funct7_5 && !ALUSrc) ? ALU_SUB : ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    3'b010:  ALUControl = ALU_CMP;
                    default: ALUControl = ALU_PASSB;
                endcase
            end
            default:      ALUControl = ALU_PASSB;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: control decode, operand-b select and a 2-entry skid buffer.
// Optional flush port enabled by defining ALU_ISSUE_FLUSH_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
`ifdef ALU_ISSUE_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   ALUOp,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    input  logic         ALUSrc,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   ALUControl
);

    logic [3:0]   ctrl_p0;
    logic [N-1:0] b_sel_p0;
    logic [N-1:0] skid_a_p1;
    logic [N-1:0] skid_b_p1;
    logic [3:0]   skid_ctrl_p1;
    logic         flush_i;

    issue_state_t state, state_nxt;
    logic accept, consume;
    logic load_main_in, load_main_skid, load_skid;

`ifdef ALU_ISSUE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Stage p0: decode and operand select on the incoming op
    alu_ctrl_decode u_decode (
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .ALUSrc     (ALUSrc),
        .ALUControl (ctrl_p0)
    );

    assign b_sel_p0  = ALUSrc ? imm : rs2_data;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                case ({accept, consume})
                    2'b11: load_main_in = 1'b1;
                    2'b10: begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: state_nxt = EMPTY;
                    default: ;
                endcase
            end
            TWO: begin
                if (consume) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Stage p1: main (output) register and skid register
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EMPTY;
            in_ready     <= 1'b1;
            a            <= '0;
            b            <= '0;
            ALUControl   <= ALU_AND;
            skid_a_p1    <= '0;
            skid_b_p1    <= '0;
            skid_ctrl_p1 <= '0;
        end else if (flush_i) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (load_main_in) begin
                a          <= rs1_data;
                b          <= b_sel_p0;
                ALUControl <= ctrl_p0;
            end else if (load_main_skid) begin
                a          <= skid_a_p1;
                b          <= skid_b_p1;
                ALUControl <= skid_ctrl_p1;
            end
            if (load_skid) begin
                skid_a_p1    <= rs1_data;
                skid_b_p1    <= b_sel_p0;
                skid_ctrl_p1 <= ctrl_p0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed and random scoreboard bench for alu_issue.
module tb_alu_issue;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
`ifdef ALU_ISSUE_FLUSH_EN
    logic         flush;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   ALUOp;
    logic [2:0]   funct3;
    logic         funct7_5;
    logic         ALUSrc;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [N-1:0] imm;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;

    alu_issue #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ALU_ISSUE_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .ALUSrc     (ALUSrc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [132:0] sb[$];
    logic [132:0] held;
    logic         held_valid = 1'b0;
    logic         last_acc;

    function automatic logic [3:0] ref_ctrl(logic [1:0] op, logic [2:0] f3, logic f7, logic src);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b1111;
        case (f3)
            3'b000:  return (f7 && !src) ? 4'b0110 : 4'b0010;
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            3'b010:  return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [132:0] obs, input logic [132:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic src,
                         input logic [N-1:0] r1, input logic [N-1:0] r2, input logic [N-1:0] im);
        in_valid = 1'b1;
        ALUOp    = op;
        funct3   = f3;
        funct7_5 = f7;
        ALUSrc   = src;
        rs1_data = r1;
        rs2_data = r2;
        imm      = im;
    endtask

    // One clock: sample at negedge, update the model, return 1 time unit after posedge.
    task automatic step();
        logic clr;
        @(negedge clk);
        clr = reset;
`ifdef ALU_ISSUE_FLUSH_EN
        clr = clr || flush;
`endif
        if (held_valid)
            check("stall_hold", {out_valid, a, b, ALUControl}, held);
        if (!clr && out_valid && out_ready) begin
            if (sb.size() == 0)
                check("spurious_out", {1'b1, a, b, ALUControl}, 133'(0));
            else
                check("sb_order", {1'b1, a, b, ALUControl}, sb.pop_front());
        end
        last_acc = !clr && in_valid && in_ready;
        if (last_acc)
            sb.push_back({1'b1, rs1_data, (ALUSrc ? imm : rs2_data),
                          ref_ctrl(ALUOp, funct3, funct7_5, ALUSrc)});
        held_valid = !clr && out_valid && !out_ready;
        held       = {out_valid, a, b, ALUControl};
        if (clr) sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cnt;
        int cyc;
        reset     = 1'b1;
`ifdef ALU_ISSUE_FLUSH_EN
        flush     = 1'b0;
`endif
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUOp = '0; funct3 = '0; funct7_5 = 1'b0; ALUSrc = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0;
        step();
        step();
        check("rst_out_valid", 133'(out_valid), 133'(0));
        check("rst_in_ready",  133'(in_ready),  133'(1));
        check("rst_data",      {1'b0, a, b, ALUControl}, 133'(0));
        reset = 1'b0;

        // single SUB op
        out_ready = 1'b1;
        drive(2'b10, 3'b000, 1'b1, 1'b0, 64'd5, 64'd3, 64'd0);
        step();
        in_valid = 1'b0;
        check("t1_valid", 133'(out_valid), 133'(1));
        check("t1_data", {1'b0, a, b, ALUControl}, {1'b0, 64'd5, 64'd3, 4'b0110});
        step();
        check("t1_drop", 133'(out_valid), 133'(0));

        // immediate form ignores funct7_5
        drive(2'b10, 3'b000, 1'b1, 1'b1, 64'd9, 64'd7, '1);
        step();
        in_valid = 1'b0;
        check("t2_data", {1'b0, a, b, ALUControl}, {1'b0, 64'd9, {N{1'b1}}, 4'b0010});
        step();

        // back-to-back A, B, C with execute stalled
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 1'b0, 1'b1, 64'h11, 64'h12, 64'h13);
        step();
        drive(2'b10, 3'b111, 1'b0, 1'b0, 64'h21, 64'h22, 64'h23);
        step();
        check("t3_ready_low", 133'(in_ready), 133'(0));
        drive(2'b10, 3'b110, 1'b0, 1'b0, 64'h31, 64'h32, 64'h33);
        step();
        check("t3_a_held", {1'b0, a, b, ALUControl}, {1'b0, 64'h11, 64'h13, 4'b0010});
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        check("t3_sb_empty", 133'(sb.size()), 133'(0));
        check("t3_idle", 133'(out_valid), 133'(0));

        // random streaming with random back-pressure
        acc_cnt  = 0;
        cyc      = 0;
        last_acc = 1'b1;
        while (acc_cnt < 100 && cyc < 3000) begin
            if (!(in_valid && !last_acc)) begin
                drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom});
                in_valid = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (last_acc) acc_cnt++;
            cyc++;
        end
        check("t4_accepted", 133'(acc_cnt), 133'(100));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t4_drained", 133'(sb.size()), 133'(0));

        // reset while in TWO, with an op offered in the reset cycle
        out_ready = 1'b0;
        drive(2'b01, 3'b000, 1'b0, 1'b0, 64'h41, 64'h42, 64'h43);
        step();
        drive(2'b11, 3'b000, 1'b0, 1'b0, 64'h51, 64'h52, 64'h53);
        step();
        check("t5_two", 133'(in_ready), 133'(0));
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("t5_valid", 133'(out_valid), 133'(0));
        check("t5_ready", 133'(in_ready), 133'(1));
        check("t5_data", {1'b0, a, b, ALUControl}, 133'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t5_no_stale", 133'(out_valid), 133'(0));

`ifdef ALU_ISSUE_FLUSH_EN
        out_ready = 1'b0;
        drive(2'b10, 3'b010, 1'b0, 1'b0, 64'h61, 64'h62, 64'h63);
        step();
        drive(2'b10, 3'b110, 1'b0, 1'b1, 64'h71, 64'h72, 64'h73);
        step();
        drive(2'b10, 3'b111, 1'b0, 1'b1, 64'h81, 64'h82, 64'h83);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_valid", 133'(out_valid), 133'(0));
        check("t6_ready", 133'(in_ready), 133'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t6_no_emit", 133'(out_valid), 133'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
